// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line and ack in, byte/flags/debug state out.
// The master modport is the receiver; the slave modport is the line driver / byte consumer.
interface uart_rx_if;
   logic       rx_pin;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;
   logic [1:0] rx_state;

   // rx_valid is a level: it stays high until the consumer's rx_ack edge, and a byte
   // landing on that same edge keeps it high with the new data.
   modport master (
      input  rx_pin, rx_ack,
      output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy, rx_state
   );

   modport slave (
      output rx_pin, rx_ack,
      input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy, rx_state
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-deep holding register, framing-error pulse and sticky overrun.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer on rx_pin (+2 cycles of latency).
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input logic     clk,
   input logic     reset,
   uart_rx_if.master bus
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int         HALF        = (CLKS_PER_BIT - 1) / 2;
   localparam logic [7:0] BIT_RELOAD  = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] HALF_RELOAD = (HALF == 0) ? 8'd0 : 8'(HALF - 1);

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic sync1, sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.rx_pin;
         sync2 <= sync1;
      end
   end

   assign rx_s = sync2;
`else
   assign rx_s = bus.rx_pin;
`endif

   state_t     state_q, state_n;
   logic [7:0] cnt_q, cnt_n;
   logic [2:0] bits_q, bits_n;
   logic [7:0] shift_q, shift_n;
   logic       armed_q, armed_n;
   logic [7:0] data_q, data_n;
   logic       valid_q, valid_n;
   logic       ferr_q, ferr_n;
   logic       ovr_q, ovr_n;
   logic       new_byte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         bits_q  <= 3'd0;
         shift_q <= 8'd0;
         armed_q <= 1'b0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bits_q  <= bits_n;
         shift_q <= shift_n;
         armed_q <= armed_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
         ovr_q   <= ovr_n;
      end
   end

   // cnt counts down to the next sample point; a sample is taken on the edge where it reads 0.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      bits_n   = bits_q;
      shift_n  = shift_q;
      armed_n  = armed_q;
      data_n   = data_q;
      valid_n  = valid_q;
      ferr_n   = 1'b0;
      ovr_n    = ovr_q;
      new_byte = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_s) armed_n = 1'b1;
            if (armed_q && !rx_s) begin
               bits_n = 3'd0;
               if (HALF == 0) begin
                  state_n = DATA;
                  cnt_n   = BIT_RELOAD;
               end else begin
                  state_n = START;
                  cnt_n   = HALF_RELOAD;
               end
            end
         end
         START: begin
            if (cnt_q == 8'd0) begin
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  cnt_n   = BIT_RELOAD;
               end
            end else begin
               cnt_n = cnt_q - 8'd1;
            end
         end
         DATA: begin
            if (cnt_q == 8'd0) begin
               shift_n = {rx_s, shift_q[7:1]};
               cnt_n   = BIT_RELOAD;
               bits_n  = bits_q + 3'd1;
               if (bits_q == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt_q - 8'd1;
            end
         end
         STOP: begin
            if (cnt_q == 8'd0) begin
               state_n = IDLE;
               if (rx_s) begin
                  new_byte = 1'b1;
                  data_n   = shift_q;
               end else begin
                  ferr_n  = 1'b1;
                  armed_n = 1'b0;
               end
            end else begin
               cnt_n = cnt_q - 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A byte landing on the ack edge wins: valid stays up and no overrun is flagged.
      if (new_byte) begin
         valid_n = 1'b1;
         if (valid_q && !bus.rx_ack) ovr_n = 1'b1;
      end else if (bus.rx_ack && valid_q) begin
         valid_n = 1'b0;
         ovr_n   = 1'b0;
      end
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_overrun   = ovr_q;
   assign bus.rx_busy      = (state_q != IDLE);
   assign bus.rx_state     = state_q;

endmodule
